// File: rtl/pixel_sequencer.sv
// Pixel-array sequencer: erase, expose, convert and N_READ read phases with run-time lengths and fixed gaps.
// All outputs registered one cycle after the deciding edge; no backpressure, abort ends a frame at once.
module pixel_sequencer #(
  parameter int CNT_W      = 8,
  parameter int N_READ     = 2,
  parameter int GAP_CYCLES = 1,
  parameter int FRM_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic [CNT_W-1:0]  erase_len,
  input  logic [CNT_W-1:0]  expose_len,
  input  logic [CNT_W-1:0]  convert_len,
  input  logic [CNT_W-1:0]  read_len,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [N_READ-1:0] read,
  output logic              busy,
  output logic              frame_done,
  output logic [FRM_W-1:0]  frame_cnt
);

  localparam int PH_DONE = N_READ + 3;
  localparam int PH_W    = $clog2(PH_DONE + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, ERASE, GAP, EXPOSE, CONVERT, READ, DONE} state_t;

  state_t            state;
  state_t            tgt_state;
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   tgt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cur_len;
  logic [CNT_W-1:0]  erase_q;
  logic [CNT_W-1:0]  expose_q;
  logic [CNT_W-1:0]  convert_q;
  logic [CNT_W-1:0]  read_q;
  logic [N_READ-1:0] tgt_read;
  logic              restart;
  logic              phase_last;
  logic              jump;
  logic              to_gap;

  // Phase index: 0 erase, 1 expose, 2 convert, 3+r read row r, PH_DONE frame end.
  // Returns the first phase at or after 'from' whose length is non-zero.
  function automatic logic [PH_W-1:0] first_phase(input int from,
                                                  input logic [CNT_W-1:0] e,
                                                  input logic [CNT_W-1:0] x,
                                                  input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] r);
    int   p;
    logic nz;
    p = PH_DONE;
    for (int i = PH_DONE - 1; i >= 0; i--) begin
      nz = (i == 0) ? (e != '0) : (i == 1) ? (x != '0) : (i == 2) ? (c != '0) : (r != '0);
      if (i >= from && nz) p = i;
    end
    return PH_W'(p);
  endfunction

  always_comb begin
    restart = (state == IDLE) || (state == DONE);
    // A new frame reads the live length inputs; inside a frame only the latched copies count.
    tgt = restart ? first_phase(0, erase_len, expose_len, convert_len, read_len)
                  : first_phase(int'(ph) + 1, erase_q, expose_q, convert_q, read_q);
    tgt_read  = '0;
    tgt_state = READ;
    if (tgt == PH_W'(0))            tgt_state = ERASE;
    else if (tgt == PH_W'(1))       tgt_state = EXPOSE;
    else if (tgt == PH_W'(2))       tgt_state = CONVERT;
    else if (tgt == PH_W'(PH_DONE)) tgt_state = DONE;
    else                            tgt_read  = N_READ'(1) << (tgt - PH_W'(3));

    case (state)
      ERASE:   cur_len = erase_q;
      EXPOSE:  cur_len = expose_q;
      CONVERT: cur_len = convert_q;
      default: cur_len = read_q;
    endcase
    phase_last = (state inside {ERASE, EXPOSE, CONVERT, READ}) && (cnt == cur_len - 1'b1);

    case (state)
      IDLE:    jump = start && !abort;
      GAP:     jump = (cnt == GAP_LAST);
      DONE:    jump = cont;
      default: jump = phase_last && (GAP_CYCLES == 0);
    endcase
    to_gap = phase_last && (GAP_CYCLES != 0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ph         <= '0;
      cnt        <= '0;
      erase_q    <= '0;
      expose_q   <= '0;
      convert_q  <= '0;
      read_q     <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        erase   <= 1'b0;
        expose  <= 1'b0;
        convert <= 1'b0;
        read    <= '0;
      end else if (jump) begin
        state   <= tgt_state;
        ph      <= tgt;
        cnt     <= '0;
        busy    <= 1'b1;
        erase   <= (tgt_state == ERASE);
        expose  <= (tgt_state == EXPOSE);
        convert <= (tgt_state == CONVERT);
        read    <= tgt_read;
        if (tgt_state == DONE) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 1'b1;
        end
        if (restart) begin
          erase_q   <= erase_len;
          expose_q  <= expose_len;
          convert_q <= convert_len;
          read_q    <= read_len;
        end
      end else if (to_gap) begin
        state   <= GAP;
        cnt     <= '0;
        erase   <= 1'b0;
        expose  <= 1'b0;
        convert <= 1'b0;
        read    <= '0;
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Bench for pixel_sequencer: two configurations driven together, checked against a per-frame timeline model.
module tb_pixel_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, cont, abort;
  logic [7:0] erase_len, expose_len, convert_len, read_len;

  logic        er0, ex0, cv0, bz0, fd0;
  logic [1:0]  rd0;
  logic [15:0] fc0;
  logic        er1, ex1, cv1, bz1, fd1;
  logic [3:0]  rd1;
  logic [15:0] fc1;

  pixel_sequencer #(.CNT_W(8), .N_READ(2), .GAP_CYCLES(1), .FRM_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
    .erase_len(erase_len), .expose_len(expose_len), .convert_len(convert_len), .read_len(read_len),
    .erase(er0), .expose(ex0), .convert(cv0), .read(rd0), .busy(bz0), .frame_done(fd0), .frame_cnt(fc0)
  );

  pixel_sequencer #(.CNT_W(8), .N_READ(4), .GAP_CYCLES(0), .FRM_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
    .erase_len(erase_len), .expose_len(expose_len), .convert_len(convert_len), .read_len(read_len),
    .erase(er1), .expose(ex1), .convert(cv1), .read(rd1), .busy(bz1), .frame_done(fd1), .frame_cnt(fc1)
  );

  // Packed view: bit8 busy, bit7 frame_done, bits6:3 read rows, bit2 convert, bit1 expose, bit0 erase.
  logic [8:0] v0, v1;
  assign v0 = {bz0, fd0, 2'b00, rd0, cv0, ex0, er0};
  assign v1 = {bz1, fd1, rd1, cv1, ex1, er1};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on acceptance a whole frame is laid out as a list of per-cycle output codes.
  logic [7:0]  tl [2][0:1023];
  int          tl_len [2];
  int          tl_pos [2];
  logic [7:0]  cur_m  [2];
  logic        busy_m [2];
  logic [15:0] fcnt_m [2];
  bit          chk_en = 1'b0;

  function automatic int nr_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic push(input int d, input logic [7:0] code);
    tl[d][tl_len[d]] = code;
    tl_len[d]++;
  endtask

  task automatic build(input int d);
    int         len;
    logic [7:0] code;
    tl_len[d] = 0;
    tl_pos[d] = 0;
    for (int p = 0; p < 3 + nr_of(d); p++) begin
      case (p)
        0:       len = int'(erase_len);
        1:       len = int'(expose_len);
        2:       len = int'(convert_len);
        default: len = int'(read_len);
      endcase
      code = (p < 3) ? 8'(1 << p) : 8'(8 << (p - 3));
      for (int k = 0; k < len; k++) push(d, code);
      if (len > 0) for (int k = 0; k < gap_of(d); k++) push(d, 8'h00);
    end
    push(d, 8'h80);
  endtask

  task automatic pop(input int d);
    cur_m[d] = tl[d][tl_pos[d]];
    tl_pos[d]++;
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        busy_m[d] = 1'b0;
        cur_m[d]  = 8'h00;
        fcnt_m[d] = 16'h0;
      end else begin
        if (busy_m[d]) begin
          if (abort) begin
            busy_m[d] = 1'b0;
            cur_m[d]  = 8'h00;
          end else if (tl_pos[d] < tl_len[d]) begin
            pop(d);
          end else if (cont) begin
            build(d);
            pop(d);
          end else begin
            busy_m[d] = 1'b0;
            cur_m[d]  = 8'h00;
          end
        end else if (start && !abort) begin
          build(d);
          busy_m[d] = 1'b1;
          pop(d);
        end
        if (cur_m[d][7]) fcnt_m[d] = fcnt_m[d] + 16'h1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_cfg0", 16'(v0), 16'({busy_m[0], cur_m[0]}));
      check("cnt_cfg0", fc0, fcnt_m[0]);
      check("out_cfg1", 16'(v1), 16'({busy_m[1], cur_m[1]}));
      check("cnt_cfg1", fc1, fcnt_m[1]);
    end
  end

  function automatic logic [7:0] rnd_len();
    return ($urandom % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 12));
  endfunction

  logic [8:0]  r0 [0:40];
  logic [8:0]  r1 [0:40];
  logic [15:0] f0 [0:40];
  logic [15:0] f1 [0:40];

  initial begin
    reset = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    erase_len = 8'd0; expose_len = 8'd0; convert_len = 8'd0; read_len = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_out0", 16'(v0), 16'h0);
    check("reset_out1", 16'(v1), 16'h0);
    check("reset_cnt0", fc0, 16'h0);

    // Single shot 5/10/8/3 with start pulsed in cycle 0; a mid-frame length change and a
    // start while busy must both leave the timing untouched.
    reset = 1'b1;
    erase_len = 8'd5; expose_len = 8'd10; convert_len = 8'd8; read_len = 8'd3;
    start = 1'b1;
    r0[0] = v0; r1[0] = v1; f0[0] = fc0; f1[0] = fc1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start = (c == 10 || c == 11);
      if (c == 3) expose_len = 8'd4;
      r0[c] = v0; r1[c] = v1; f0[c] = fc0; f1[c] = fc1;
    end
    check("c0_idle_cycle0", 16'(r0[0]),  16'h000);
    check("c0_erase_c1",    16'(r0[1]),  16'h101);
    check("c0_erase_c5",    16'(r0[5]),  16'h101);
    check("c0_gap_c6",      16'(r0[6]),  16'h100);
    check("c0_expose_c7",   16'(r0[7]),  16'h102);
    check("c0_expose_c16",  16'(r0[16]), 16'h102);
    check("c0_gap_c17",     16'(r0[17]), 16'h100);
    check("c0_convert_c18", 16'(r0[18]), 16'h104);
    check("c0_read0_c27",   16'(r0[27]), 16'h108);
    check("c0_read1_c31",   16'(r0[31]), 16'h110);
    check("c0_gap_c34",     16'(r0[34]), 16'h100);
    check("c0_done_c35",    16'(r0[35]), 16'h180);
    check("c0_idle_c36",    16'(r0[36]), 16'h000);
    check("c0_cnt_c34",     f0[34], 16'd0);
    check("c0_cnt_c35",     f0[35], 16'd1);
    check("c1_expose_c6",   16'(r1[6]),  16'h102);
    check("c1_read0_c24",   16'(r1[24]), 16'h108);
    check("c1_read3_c33",   16'(r1[33]), 16'h140);
    check("c1_done_c36",    16'(r1[36]), 16'h180);
    check("c1_idle_c37",    16'(r1[37]), 16'h000);
    check("c1_cnt_c37",     f1[37], 16'd1);

    // Randomised traffic: starts, continuous runs, aborts, resets and mid-frame length changes.
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      #1;
      start = ($urandom % 6 == 0);
      abort = ($urandom % 200 == 0);
      reset = ($urandom % 1500 != 0);
      if ($urandom % 40 == 0) cont = ~cont;
      if ($urandom % 8 == 0) erase_len   = rnd_len();
      if ($urandom % 8 == 0) expose_len  = rnd_len();
      if ($urandom % 8 == 0) convert_len = rnd_len();
      if ($urandom % 8 == 0) read_len    = rnd_len();
      if ($urandom % 300 == 0) begin
        erase_len = 8'd0; expose_len = 8'd0; convert_len = 8'd0; read_len = 8'd0;
      end
    end
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
